ledwalker_n: RTL and testbench

LEDWALKER_N -- requirements
Module: ledwalker_n

---
 rtl/ledwalker_pkg.sv | 19 +
 rtl/stbgen.sv | 35 +++
 rtl/ledwalker_n.sv | 183 ++++++++++++++++++
 tb/tb_ledwalker_n.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ledwalker_pkg.sv
// Shared encodings for the LED walker: walk modes, ONESHOT FSM states and
// direction values. Imported by the top level.
package ledwalker_pkg;

    // Walk modes as presented on i_mode
    localparam logic [1:0] MODE_BOUNCE   = 2'b00;
    localparam logic [1:0] MODE_ROT_UP   = 2'b01;
    localparam logic [1:0] MODE_ROT_DOWN = 2'b10;
    localparam logic [1:0] MODE_ONESHOT  = 2'b11;

    // ONESHOT FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // Walk direction
    localparam logic [0:0] DIR_DOWN = 1'b0;
    localparam logic [0:0] DIR_UP   = 1'b1;

endpackage

// File: rtl/stbgen.sv
// Step tick generator: a down-counter that loads DIVIDER-1, counts to zero
// and reloads, producing a registered one-cycle strobe every DIVIDER cycles.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   stb - one-cycle pulse, the cycle after the counter reads zero
module stbgen #(
    parameter int DIVIDER = 8
) (
    input  logic clk,
    input  logic rst,
    output logic stb
);

    localparam int               CNT_W  = $clog2(DIVIDER);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Free-running tick counter and registered strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= RELOAD;
            stb   <= 1'b0;
        end else if (cnt_r == ZERO) begin
            cnt_r <= RELOAD;
            stb   <= 1'b1;
        end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            stb   <= 1'b0;
        end
    end

endmodule

// File: rtl/ledwalker_n.sv
// LED walker: moves a single lit LED across NLEDS outputs once per step tick
// in bounce, rotate-up, rotate-down or triggered one-shot sweep mode.
// Ports:
//   i_clk   - clock
//   i_reset - asynchronous active-high reset
//   i_mode  - walk mode (see ledwalker_pkg)
//   i_pause - freeze position while high
//   i_start - ONESHOT launch request, level-sampled
//   o_led   - one-hot LED drive (registered copy of position)
//   o_busy  - high while a ONESHOT launch is pending or sweeping
//   o_stb   - one-cycle step tick pulse
module ledwalker_n
    import ledwalker_pkg::*;
#(
    parameter int NLEDS       = 8,
    parameter int CLK_RATE_HZ = 12_000_000,
    parameter int STEP_HZ     = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    input  logic             i_pause,
    input  logic             i_start,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy,
    output logic             o_stb
);

    localparam int               DIVIDER = CLK_RATE_HZ / STEP_HZ;
    localparam int               POS_W   = $clog2(NLEDS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NLEDS - 1);
    localparam logic [POS_W-1:0] POS_MIN = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [NLEDS-1:0] LED_ONE = NLEDS'(1);

    logic [POS_W-1:0] pos_r, pos_s;
    logic             dir_r, dir_s;
    logic [1:0]       mode_r, mode_s;
    logic             state_r, state_s;
    logic             pending_r, pending_s;
    logic             busy_s;
    logic             step_s;
    logic [POS_W-1:0] bnc_pos_s;
    logic             bnc_dir_s;

    stbgen #(
        .DIVIDER (DIVIDER)
    ) u_stbgen (
        .clk (i_clk),
        .rst (i_reset),
        .stb (o_stb)
    );

    // Bounce stepping from the current position; endpoints flip direction
    // and move away on the same step, so there is no dwell at either end.
    always_comb begin
        bnc_pos_s = pos_r;
        bnc_dir_s = dir_r;
        if (dir_r == DIR_UP) begin
            if (pos_r == POS_MAX) begin
                bnc_dir_s = DIR_DOWN;
                bnc_pos_s = pos_r - POS_ONE;
            end else begin
                bnc_pos_s = pos_r + POS_ONE;
            end
        end else begin
            if (pos_r == POS_MIN) begin
                bnc_dir_s = DIR_UP;
                bnc_pos_s = pos_r + POS_ONE;
            end else begin
                bnc_pos_s = pos_r - POS_ONE;
            end
        end
    end

    // Next-state logic for position, direction, mode and the ONESHOT FSM
    always_comb begin
        step_s    = o_stb & ~i_pause;
        pos_s     = pos_r;
        dir_s     = dir_r;
        mode_s    = mode_r;
        state_s   = state_r;
        pending_s = pending_r;
        busy_s    = o_busy;

        // Launch requests are only accepted while idle in ONESHOT; a request
        // during a sweep is dropped rather than queued.
        if ((mode_r == MODE_ONESHOT) && (state_r == ST_IDLE) && i_start) begin
            pending_s = 1'b1;
            busy_s    = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        if (step_s) begin
            mode_s = i_mode;
            case (i_mode)
                MODE_BOUNCE: begin
                    pos_s     = bnc_pos_s;
                    dir_s     = bnc_dir_s;
                    state_s   = ST_IDLE;
                    pending_s = 1'b0;
                    busy_s    = 1'b0;
                end
                MODE_ROT_UP: begin
                    dir_s     = DIR_UP;
                    pos_s     = (pos_r == POS_MAX) ? POS_MIN : pos_r + POS_ONE;
                    state_s   = ST_IDLE;
                    pending_s = 1'b0;
                    busy_s    = 1'b0;
                end
                MODE_ROT_DOWN: begin
                    dir_s     = DIR_DOWN;
                    pos_s     = (pos_r == POS_MIN) ? POS_MAX : pos_r - POS_ONE;
                    state_s   = ST_IDLE;
                    pending_s = 1'b0;
                    busy_s    = 1'b0;
                end
                MODE_ONESHOT: begin
                    if (mode_r != MODE_ONESHOT) begin
                        // Fresh entry: park at 0 and wait for a launch
                        pos_s     = POS_MIN;
                        dir_s     = DIR_UP;
                        state_s   = ST_IDLE;
                        pending_s = 1'b0;
                        busy_s    = 1'b0;
                    end else if (state_r == ST_SWEEP) begin
                        pos_s = bnc_pos_s;
                        dir_s = bnc_dir_s;
                        if (bnc_pos_s == POS_MIN) begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                        end else begin
                            state_s = ST_SWEEP;
                        end
                    end else if (pending_r) begin
                        pos_s     = POS_ONE;
                        dir_s     = DIR_UP;
                        state_s   = ST_SWEEP;
                        pending_s = 1'b0;
                        busy_s    = 1'b1;
                    end else begin
                        pos_s = POS_MIN;
                    end
                end
                default: begin
                    pos_s = pos_r;
                end
            endcase
        end else begin
            mode_s = mode_r;
        end
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pos_r     <= POS_MIN;
            dir_r     <= DIR_UP;
            mode_r    <= MODE_BOUNCE;
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            pos_r     <= pos_s;
            dir_r     <= dir_s;
            mode_r    <= mode_s;
            state_r   <= state_s;
            pending_r <= pending_s;
            o_busy    <= busy_s;
        end
    end

    // Registered one-hot LED drive, one cycle behind pos
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_led <= LED_ONE;
        end else begin
            o_led <= LED_ONE << pos_r;
        end
    end

endmodule

// File: tb/tb_ledwalker_n.sv
// Directed self-checking bench for ledwalker_n (NLEDS=4, DIVIDER=8), plus
// NLEDS=2 and NLEDS=32 instances (DIVIDER=2) checked in free-running BOUNCE.
module tb_ledwalker_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        pause = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  led;
    logic        busy;
    logic        stb;
    logic [1:0]  led2;
    logic        busy2;
    logic        stb2;
    logic [31:0] led32;
    logic        busy32;
    logic        stb32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ledwalker_n #(.NLEDS(4), .CLK_RATE_HZ(8), .STEP_HZ(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_mode(mode), .i_pause(pause),
        .i_start(start), .o_led(led), .o_busy(busy), .o_stb(stb));

    ledwalker_n #(.NLEDS(2), .CLK_RATE_HZ(2), .STEP_HZ(1)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_mode(2'b00), .i_pause(1'b0),
        .i_start(1'b0), .o_led(led2), .o_busy(busy2), .o_stb(stb2));

    ledwalker_n #(.NLEDS(32), .CLK_RATE_HZ(2), .STEP_HZ(1)) dut32 (
        .i_clk(clk), .i_reset(reset), .i_mode(2'b00), .i_pause(1'b0),
        .i_start(1'b0), .o_led(led32), .o_busy(busy32), .o_stb(stb32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until o_stb is seen high (bounded)
    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stb === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // One step: busy sampled after pos updates, led sampled one cycle later
    task automatic step_obs(output logic [3:0] l, output logic b1);
        bit ok;
        wait_stb(ok);
        check("stb_seen", {63'd0, ok}, 64'd1);
        tick();
        b1 = busy;
        tick();
        l = led;
    endtask

    task automatic count_to_stb(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (stb !== 1'b1 && n < 20);
    endtask

    logic [3:0]  exp_bnc [6]  = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd2, 4'd4};
    logic [3:0]  exp_rup [5]  = '{4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
    logic [3:0]  exp_rdn [5]  = '{4'd4, 4'd2, 4'd1, 4'd8, 4'd4};
    logic [3:0]  exp_sw  [6]  = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1};
    logic        exp_swb [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [3:0]  l;
        logic        b1;
        bit          ok;
        int          n;
        int          chg2;
        int          chg32;
        logic [1:0]  prev2;
        logic [31:0] prev32;
        logic [31:0] e32;
        logic [1:0]  e2;

        // Reset state, held across edges
        #23;
        check("rst_led", {60'd0, led}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stb", {63'd0, stb}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // First strobe 8 edges after release, one cycle wide, period 8
        count_to_stb(n);
        check("first_stb_edges", 64'(n), 64'd8);
        tick();
        check("stb_width", {63'd0, stb}, 64'd0);
        tick();
        check("bounce_0", {60'd0, led}, 64'd2);
        n = 2;
        do begin
            tick();
            n++;
        end while (stb !== 1'b1 && n < 20);
        check("stb_period", 64'(n), 64'd8);
        tick();
        tick();
        check("bounce_1", {60'd0, led}, 64'd4);
        for (int i = 0; i < 6; i++) begin
            step_obs(l, b1);
            check($sformatf("bounce_%0d", i + 2), {60'd0, l}, {60'd0, exp_bnc[i]});
        end

        // ROT_UP then ROT_DOWN (pos=2, dir up at this point)
        mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step_obs(l, b1);
            check($sformatf("rot_up_%0d", i), {60'd0, l}, {60'd0, exp_rup[i]});
        end
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step_obs(l, b1);
            check($sformatf("rot_dn_%0d", i), {60'd0, l}, {60'd0, exp_rdn[i]});
        end

        // Back to BOUNCE keeps dir down; pause at pos 0 for 3 ticks
        mode = 2'b00;
        step_obs(l, b1);
        check("bnc_entry_0", {60'd0, l}, 64'd2);
        step_obs(l, b1);
        check("bnc_entry_1", {60'd0, l}, 64'd1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_obs(l, b1);
            check($sformatf("pause_hold_%0d", i), {60'd0, l}, 64'd1);
        end
        pause = 1'b0;
        step_obs(l, b1);
        check("pause_resume_0", {60'd0, l}, 64'd2);
        step_obs(l, b1);
        check("pause_resume_1", {60'd0, l}, 64'd4);

        // ONESHOT: entry parks at 0, then a one-cycle launch
        mode = 2'b11;
        step_obs(l, b1);
        check("os_entry_led", {60'd0, l}, 64'd1);
        check("os_entry_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("os_busy_rise", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            step_obs(l, b1);
            check($sformatf("os_led_%0d", i), {60'd0, l}, {60'd0, exp_sw[i]});
            check($sformatf("os_busy_%0d", i), {63'd0, b1}, {63'd0, exp_swb[i]});
            if (i == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        step_obs(l, b1);
        check("os_no_requeue_led", {60'd0, l}, 64'd1);
        check("os_no_requeue_busy", {63'd0, b1}, 64'd0);

        // Asynchronous reset mid-sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        step_obs(l, b1);
        check("os2_led_0", {60'd0, l}, 64'd2);
        step_obs(l, b1);
        check("os2_led_1", {60'd0, l}, 64'd4);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_led", {60'd0, led}, 64'd1);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_stb", {63'd0, stb}, 64'd0);
        mode = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        count_to_stb(n);
        check("rst2_first_stb_edges", 64'(n), 64'd8);
        tick();
        check("rst2_busy", {63'd0, busy}, 64'd0);
        tick();
        check("rst2_led", {60'd0, led}, 64'd2);

        // NLEDS=2 and NLEDS=32 builds from a clean reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chg2 = 0;
        chg32 = 0;
        prev2 = led2;
        prev32 = led32;
        check("n2_reset_led", {62'd0, led2}, 64'd1);
        check("n32_reset_led", {32'd0, led32}, 64'd1);
        for (int c = 0; c < 200; c++) begin
            tick();
            check("n2_onehot", {63'd0, $onehot(led2)}, 64'd1);
            check("n32_onehot", {63'd0, $onehot(led32)}, 64'd1);
            if (led2 !== prev2) begin
                chg2++;
                e2 = (chg2 % 2 == 1) ? 2'd2 : 2'd1;
                check($sformatf("n2_step_%0d", chg2), {62'd0, led2}, {62'd0, e2});
                prev2 = led2;
            end
            if (led32 !== prev32) begin
                chg32++;
                if (chg32 <= 62) begin
                    e32 = 32'd1 << ((chg32 <= 31) ? chg32 : (62 - chg32));
                    check($sformatf("n32_step_%0d", chg32), {32'd0, led32}, {32'd0, e32});
                end
                prev32 = led32;
            end
        end
        check("n2_enough_steps", {63'd0, (chg2 >= 62)}, 64'd1);
        check("n32_full_period", {63'd0, (chg32 >= 62)}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
